// File: rtl/mcs4_rom_arb.sv
// mcs4_rom_arb
// Program-memory arbiter between an i4004 core and a host port.
// The core's 8-phase instruction cycle is tracked from cpu_sync. The 12-bit
// fetch address is assembled from the bus during A1..A3, and the opcode is
// returned on M1/M2. Every memory cycle the core does not need is offered to
// the host for program load and readback. The block also drives the core's
// reset from run.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   run                 1 = core released, 0 = core held in reset
//   cpu_rst             registered reset to the core
//   cpu_sync            core sync (high in X3)
//   cpu_dbus_out/in     core data bus (address nibbles out, opcode nibbles in)
//   mem_*               single-port 4096x8 synchronous memory, read data 1 cycle late
//   host_*              host access port (req/ack, read data return)
//   sync_err            sticky out-of-phase sync flag
//   fetch_cnt           wrapping count of core fetches
//   last_fetch_addr     address of the most recent core fetch
//
// Host handshake: the host raises host_req with host_we/host_addr/host_wdata
// and keeps them stable. A cycle with host_ack=1 performs the access, and
// the request is consumed at that clock edge. Holding host_req high across
// consecutive acks issues back-to-back accesses. A read returns
// host_rvalid=1 with host_rdata in the cycle after its ack.

module mcs4_rom_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        cpu_rst,
  input  logic        cpu_sync,
  input  logic [3:0]  cpu_dbus_out,
  output logic [3:0]  cpu_dbus_in,
  output logic        mem_en,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [11:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic        host_rvalid,
  output logic [7:0]  host_rdata,
  output logic        sync_err,
  output logic [15:0] fetch_cnt,
  output logic [11:0] last_fetch_addr
);

  typedef enum logic [2:0] {
    PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
  } ph_t;

  ph_t         r_ph;
  logic        r_locked;
  logic        r_cpu_rst;
  logic [3:0]  r_addr_lo;
  logic [3:0]  r_addr_mid;
  logic [7:0]  r_fetch_byte;
  logic        r_rd_pend;
  logic [7:0]  r_rdata_hold;
  logic        r_sync_err;
  logic [15:0] r_fetch_cnt;
  logic [11:0] r_last_fetch_addr;

  logic        w_cpu_slot;
  logic [11:0] w_fetch_addr;
  logic        w_host_ack;

  // The core owns the memory only in A3. Any host request in that cycle
  // is delayed by exactly one cycle.
  assign w_cpu_slot   = r_locked && (r_ph == PH_A3) && !r_cpu_rst;
  assign w_fetch_addr = {cpu_dbus_out, r_addr_mid, r_addr_lo};
  assign w_host_ack   = host_req && !rst && !w_cpu_slot;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 12'd0;
    mem_wdata = 8'd0;
    if (w_cpu_slot) begin
      mem_en   = 1'b1;
      mem_addr = w_fetch_addr;
    end else if (w_host_ack) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // M1 passes the high nibble straight from the memory read of A3. The byte
  // is latched so that M2 can supply the low nibble even if a host read
  // changes mem_rdata in the meantime.
  always_comb begin
    cpu_dbus_in = 4'd0;
    if (r_locked && r_ph == PH_M1)
      cpu_dbus_in = mem_rdata[7:4];
    else if (r_locked && r_ph == PH_M2)
      cpu_dbus_in = r_fetch_byte[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph              <= PH_A1;
      r_locked          <= 1'b0;
      r_cpu_rst         <= 1'b1;
      r_addr_lo         <= 4'd0;
      r_addr_mid        <= 4'd0;
      r_fetch_byte      <= 8'd0;
      r_rd_pend         <= 1'b0;
      r_rdata_hold      <= 8'd0;
      r_sync_err        <= 1'b0;
      r_fetch_cnt       <= 16'd0;
      r_last_fetch_addr <= 12'd0;
    end else begin
      r_cpu_rst <= !run;

      if (cpu_sync) r_ph <= PH_A1;
      else          r_ph <= ph_t'(r_ph + 3'd1);

      // r_cpu_rst lags run by one cycle, so the lock drops one cycle after
      // the core enters reset.
      if (r_cpu_rst)     r_locked <= 1'b0;
      else if (cpu_sync) r_locked <= 1'b1;

      if (r_locked && ((cpu_sync && r_ph != PH_X3) || (!cpu_sync && r_ph == PH_X3)))
        r_sync_err <= 1'b1;

      if (r_ph == PH_A1) r_addr_lo  <= cpu_dbus_out;
      if (r_ph == PH_A2) r_addr_mid <= cpu_dbus_out;

      if (w_cpu_slot) begin
        r_last_fetch_addr <= w_fetch_addr;
        r_fetch_cnt       <= r_fetch_cnt + 16'd1;
      end

      if (r_locked && r_ph == PH_M1) r_fetch_byte <= mem_rdata;

      // Run control does not cancel a read that is already in flight.
      r_rd_pend <= w_host_ack && !host_we;
      if (r_rd_pend) r_rdata_hold <= mem_rdata;
    end
  end

  assign cpu_rst         = r_cpu_rst;
  assign host_ack        = w_host_ack;
  assign host_rvalid     = r_rd_pend;
  assign host_rdata      = r_rd_pend ? mem_rdata : r_rdata_hold;
  assign sync_err        = r_sync_err;
  assign fetch_cnt       = r_fetch_cnt;
  assign last_fetch_addr = r_last_fetch_addr;

endmodule
